// File: rtl/gcm_aes.sv
// gcm_aes: AES-128-GCM engine for one AAD block and one plaintext block.
// Iterative AES-128 (one round per cycle, on-the-fly key expansion) plus a
// combinational GF(2^128) multiplier shared by the three GHASH steps.
// Build option: define GCM_AES_PARTIAL_BLOCK_EN to mask AAD/ciphertext to
// their bit sizes; otherwise any nonzero size is taken as a full block.
//
// state    | meaning
// IDLE     | no run active
// GEN_H    | H = E(K, 0)
// GEN_EJ0  | S = E(K, J0)
// GEN_ECTR | KS = E(K, inc32(J0))
// WAIT_PT  | waiting for plaintext
// ENC_C    | C = P xor KS
// GH_A     | X = A*H (or 0 without AAD)
// GH_C     | X = (X xor C)*H (skipped without plaintext)
// GH_LEN   | tag = ((X xor len)*H) xor S
// DONE     | tag held, o_tag_ready high
module gcm_aes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_new_instance,
  input  logic         i_pt_instance,
  input  logic [0:127] i_cipher_key,
  input  logic [0:95]  i_iv,
  input  logic [0:127] i_plain_text,
  input  logic [0:127] i_aad,
  input  logic [0:63]  i_plain_text_size,
  input  logic [0:63]  i_aad_size,
  output logic [0:127] o_cipher_text,
  output logic [0:127] o_tag,
  output logic         o_tag_ready
);
  typedef enum logic [3:0] {IDLE, GEN_H, GEN_EJ0, GEN_ECTR, WAIT_PT, ENC_C,
                            GH_A, GH_C, GH_LEN, DONE} state_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes + ShiftRows, then MixColumns unless this is the final round.
  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic last);
    logic [7:0] b [16];
    logic [0:127] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int n = 0; n < 16; n++) b[n] = sbox(s[8*n +: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) r[8*(4*c+w) +: 8] = b[4*((c+w)%4)+w];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = r[32*c +: 8]; a1 = r[32*c+8 +: 8]; a2 = r[32*c+16 +: 8]; a3 = r[32*c+24 +: 8];
        r[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] next_key(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] t, w0, w1, w2, w3;
    t  = {sbox(k[104 +: 8]) ^ rc, sbox(k[112 +: 8]), sbox(k[120 +: 8]), sbox(k[96 +: 8])};
    w0 = k[0:31] ^ t;
    w1 = k[32:63] ^ w0;
    w2 = k[64:95] ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Bit-serial GF(2^128) product in GCM's reflected bit order.
  function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      v = v[127] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

`ifdef GCM_AES_PARTIAL_BLOCK_EN
  function automatic logic [0:127] size_mask(input logic [0:63] sz);
    if (sz >= 64'd128) return '1;
    return ~({128{1'b1}} >> sz[57:63]);
  endfunction
`endif

  state_t       state_q;
  logic [3:0]   rnd_q;
  logic [0:127] key_q, aad_q, pt_q, st_q, rk_q, h_q, s_q, ks_q, x_q, ct_q, tag_q;
  logic [0:95]  iv_q;
  logic [0:63]  aad_size_q, pt_size_q;
  logic         pt_valid_q, ready_q;
  logic [0:127] aes_in, aes_d, rk_d, mul_a, mul_d, ct_d, aad_d;
  logic         pt_open;

  // AES round datapath, shared GHASH multiplier and masking.
  always_comb begin
    case (state_q)
      GEN_EJ0:  aes_in = {iv_q, 32'h0000_0001};
      GEN_ECTR: aes_in = {iv_q, 32'h0000_0002};
      default:  aes_in = '0;
    endcase
    if (rnd_q == 4'd0) begin
      rk_d  = next_key(key_q, 8'h01);
      aes_d = aes_round(aes_in ^ key_q, 1'b0) ^ rk_d;
    end else begin
      rk_d  = next_key(rk_q, rcon(rnd_q + 4'd1));
      aes_d = aes_round(st_q, rnd_q == 4'd9) ^ rk_d;
    end
    case (state_q)
      GH_A:    mul_a = aad_q;
      GH_C:    mul_a = x_q ^ ct_q;
      default: mul_a = x_q ^ {aad_size_q, pt_size_q};
    endcase
    mul_d = gf_mul(mul_a, h_q);
`ifdef GCM_AES_PARTIAL_BLOCK_EN
    ct_d  = (pt_q ^ ks_q) & size_mask(pt_size_q);
    aad_d = i_aad & size_mask(i_aad_size);
`else
    ct_d  = pt_q ^ ks_q;
    aad_d = i_aad;
`endif
    pt_open = state_q inside {IDLE, GEN_H, GEN_EJ0, GEN_ECTR, WAIT_PT};
  end

  // Sequencer, capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      pt_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      ct_q       <= '0;
      tag_q      <= '0;
      key_q      <= '0;
      iv_q       <= '0;
      aad_q      <= '0;
      pt_q       <= '0;
      aad_size_q <= '0;
      pt_size_q  <= '0;
      st_q       <= '0;
      rk_q       <= '0;
      h_q        <= '0;
      s_q        <= '0;
      ks_q       <= '0;
      x_q        <= '0;
    end else begin
      if (i_pt_instance && (i_new_instance || pt_open)) begin
        pt_q       <= i_plain_text;
        pt_valid_q <= 1'b1;
      end
      if (i_new_instance) begin
        key_q      <= i_cipher_key;
        iv_q       <= i_iv;
        aad_q      <= aad_d;
        aad_size_q <= i_aad_size;
        pt_size_q  <= i_plain_text_size;
        rnd_q      <= '0;
        ready_q    <= 1'b0;
        state_q    <= GEN_H;
      end else begin
        case (state_q)
          GEN_H, GEN_EJ0, GEN_ECTR: begin
            st_q  <= aes_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_q + 4'd1;
            if (rnd_q == 4'd9) begin
              rnd_q <= '0;
              if (state_q == GEN_H) begin
                h_q     <= aes_d;
                state_q <= GEN_EJ0;
              end else if (state_q == GEN_EJ0) begin
                s_q     <= aes_d;
                state_q <= GEN_ECTR;
              end else begin
                ks_q    <= aes_d;
                state_q <= WAIT_PT;
              end
            end
          end
          // a pulse on this edge is captured now, so ENC_C can use it next cycle
          WAIT_PT: if (pt_valid_q || i_pt_instance) state_q <= ENC_C;
          ENC_C: begin
            ct_q       <= ct_d;
            pt_valid_q <= 1'b0;
            state_q    <= GH_A;
          end
          GH_A: begin
            x_q     <= (aad_size_q == 64'd0) ? '0 : mul_d;
            state_q <= GH_C;
          end
          GH_C: begin
            if (pt_size_q != 64'd0) x_q <= mul_d;
            state_q <= GH_LEN;
          end
          GH_LEN: begin
            tag_q   <= mul_d ^ s_q;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign o_cipher_text = ct_q;
  assign o_tag         = tag_q;
  assign o_tag_ready   = ready_q;
endmodule

// File: tb/tb_gcm_aes.sv
// Testbench for gcm_aes: known GCM vectors plus randomized runs checked
// against a textbook AES-128 / GHASH reference model built from first
// principles (S-box derived from GF(2^8) inversion and the affine map).
module tb_gcm_aes;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_new_instance = 1'b0;
  logic         i_pt_instance = 1'b0;
  logic [0:127] i_cipher_key = '0;
  logic [0:95]  i_iv = '0;
  logic [0:127] i_plain_text = '0;
  logic [0:127] i_aad = '0;
  logic [0:63]  i_plain_text_size = '0;
  logic [0:63]  i_aad_size = '0;
  logic [0:127] o_cipher_text;
  logic [0:127] o_tag;
  logic         o_tag_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  gcm_aes dut (
    .clk(clk), .rst_n(rst_n), .i_new_instance(i_new_instance),
    .i_pt_instance(i_pt_instance), .i_cipher_key(i_cipher_key), .i_iv(i_iv),
    .i_plain_text(i_plain_text), .i_aad(i_aad),
    .i_plain_text_size(i_plain_text_size), .i_aad_size(i_aad_size),
    .o_cipher_text(o_cipher_text), .o_tag(o_tag), .o_tag_ready(o_tag_ready));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gm8(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:127] aes_enc(input logic [0:127] key, input logic [0:127] blk);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  st [4][4];
    logic [7:0]  tp [4][4];
    logic [0:127] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm8(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = blk[8*(4*c+r) +: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tp[r][c] = sb[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd == 10) st[r][c] = tp[r][c];
          else st[r][c] = gm8(tp[r][c], 8'h02) ^ gm8(tp[(r+1)%4][c], 8'h03)
                        ^ tp[(r+2)%4][c] ^ tp[(r+3)%4][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) out[8*(4*c+r) +: 8] = st[r][c];
    return out;
  endfunction

  function automatic logic [0:127] ghash_mul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      if (v[127]) v = (v >> 1) ^ {8'he1, 120'h0};
      else v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [0:127] keep_bits(input logic [0:127] v, input logic [63:0] sz);
    logic [0:127] r;
    r = v;
`ifdef GCM_AES_PARTIAL_BLOCK_EN
    for (int i = 0; i < 128; i++) if (64'(i) >= sz) r[i] = 1'b0;
`endif
    return r;
  endfunction

  function automatic void gcm_model(input logic [0:127] k, input logic [0:95] iv,
                                    input logic [0:127] aad, input logic [63:0] asz,
                                    input logic [0:127] p, input logic [63:0] psz,
                                    output logic [0:127] c, output logic [0:127] tag);
    logic [0:127] h, s, ks, y;
    logic [0:127] blocks [$];
    h  = aes_enc(k, '0);
    s  = aes_enc(k, {iv, 32'd1});
    ks = aes_enc(k, {iv, 32'd2});
    c  = keep_bits(p ^ ks, psz);
    if (asz != 0) blocks.push_back(keep_bits(aad, asz));
    if (psz != 0) blocks.push_back(c);
    blocks.push_back({asz, psz});
    y = '0;
    foreach (blocks[i]) y = ghash_mul(y ^ blocks[i], h);
    tag = y ^ s;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] rnd_size();
    case ($urandom_range(0, 3))
      0: return 64'd0;
      1: return 64'd128;
      default: return 64'($urandom_range(1, 127));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  // Starts a run and waits for o_tag_ready; pt_delay is the posedge index
  // (0 = the start posedge) at which i_pt_instance is sampled.
  task automatic run_gcm(input logic [0:127] k, input logic [0:95] iv,
                         input logic [0:127] aad, input logic [63:0] asz,
                         input logic [0:127] p, input logic [63:0] psz,
                         input int pt_delay, output int lat, output logic rdy_after_start);
    @(posedge clk); #1;
    i_cipher_key = k; i_iv = iv; i_aad = aad; i_aad_size = asz; i_plain_text_size = psz;
    i_new_instance = 1'b1;
    i_pt_instance = (pt_delay == 0);
    i_plain_text = (pt_delay == 0) ? p : rnd128();
    @(posedge clk); #1;
    rdy_after_start = o_tag_ready;
    i_new_instance = 1'b0; i_pt_instance = 1'b0;
    i_cipher_key = rnd128(); i_iv = rnd128() >> 32; i_aad = rnd128();
    i_aad_size = 64'($urandom()); i_plain_text_size = 64'($urandom()); i_plain_text = rnd128();
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      if (n == pt_delay) begin i_pt_instance = 1'b1; i_plain_text = p; end
      @(posedge clk); #1;
      i_pt_instance = 1'b0;
      i_plain_text = rnd128();
      if (o_tag_ready) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_tag_ready !== 1'b0 || o_cipher_text !== '0 || o_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ct=%h tag=%h, expected all zero",
               o_tag_ready, o_cipher_text, o_tag);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known_vectors();
    int lat; logic r0;
    run_gcm('0, '0, '0, 64'd0, '0, 64'd0, 0, lat, r0);
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL kv1_latency: got %0d expected 35", lat); end
    checks++;
    if (o_tag !== 128'h58e2fccefa7e3061367f1d57a4e7455a) begin
      errors++; $display("FAIL kv1_tag: got %h expected 58e2fccefa7e3061367f1d57a4e7455a", o_tag);
    end
    run_gcm('0, '0, '0, 64'd0, '0, 64'd128, 0, lat, r0);
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL kv2_ready_drop: got %b expected 0", r0); end
    checks++;
    if (o_cipher_text !== 128'h0388dace60b6a392f328c2b971b2fe78) begin
      errors++; $display("FAIL kv2_ct: got %h expected 0388dace60b6a392f328c2b971b2fe78", o_cipher_text);
    end
    checks++;
    if (o_tag !== 128'hab6e47d42cec13bdf53a67b21257bddf) begin
      errors++; $display("FAIL kv2_tag: got %h expected ab6e47d42cec13bdf53a67b21257bddf", o_tag);
    end
  endtask

  task automatic test_late_pt();
    int lat; logic r0;
    run_gcm('0, '0, '0, 64'd0, '0, 64'd128, 50, lat, r0);
    checks++;
    if (lat !== 54) begin errors++; $display("FAIL late_latency: got %0d expected 54", lat); end
    checks++;
    if (o_cipher_text !== 128'h0388dace60b6a392f328c2b971b2fe78) begin
      errors++; $display("FAIL late_ct: got %h expected 0388dace60b6a392f328c2b971b2fe78", o_cipher_text);
    end
    checks++;
    if (o_tag !== 128'hab6e47d42cec13bdf53a67b21257bddf) begin
      errors++; $display("FAIL late_tag: got %h expected ab6e47d42cec13bdf53a67b21257bddf", o_tag);
    end
  endtask

  task automatic test_random();
    logic [0:127] k, aad, p, ec, et;
    logic [0:95]  iv;
    logic [63:0]  asz, psz;
    int d, lat, el;
    logic r0;
    for (int it = 0; it < 12; it++) begin
      k = rnd128(); aad = rnd128(); p = rnd128(); iv = rnd128() >> 32;
      asz = rnd_size(); psz = rnd_size();
      d = $urandom_range(0, 40);
      el = (d + 4 > 35) ? d + 4 : 35;
      gcm_model(k, iv, aad, asz, p, psz, ec, et);
      run_gcm(k, iv, aad, asz, p, psz, d, lat, r0);
      checks++;
      if (lat !== el) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, el); end
      checks++;
      if (o_cipher_text !== ec) begin
        errors++; $display("FAIL rand%0d_ct: got %h expected %h", it, o_cipher_text, ec);
      end
      checks++;
      if (o_tag !== et) begin
        errors++; $display("FAIL rand%0d_tag: got %h expected %h", it, o_tag, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] k, aad, p, ec, et;
    logic [0:95]  iv;
    int lat; logic r0;
    run_gcm(rnd128(), rnd128() >> 32, rnd128(), 64'd128, rnd128(), 64'd128, 0, lat, r0);
    k = rnd128(); aad = rnd128(); p = rnd128(); iv = rnd128() >> 32;
    gcm_model(k, iv, aad, 64'd100, p, 64'd77, ec, et);
    run_gcm(k, iv, aad, 64'd100, p, 64'd77, 1, lat, r0);
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b expected 0", r0); end
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL b2b_latency: got %0d expected 35", lat); end
    checks++;
    if (o_cipher_text !== ec || o_tag !== et) begin
      errors++; $display("FAIL b2b_result: got ct=%h tag=%h expected ct=%h tag=%h", o_cipher_text, o_tag, ec, et);
    end
  endtask

  task automatic test_abort();
    logic [0:127] k, aad, p, ec, et;
    logic [0:95]  iv;
    int lat, early; logic r0;
    @(posedge clk); #1;
    i_cipher_key = rnd128(); i_iv = rnd128() >> 32; i_aad = rnd128();
    i_aad_size = 64'd128; i_plain_text_size = 64'd128; i_plain_text = rnd128();
    i_new_instance = 1'b1; i_pt_instance = 1'b1;
    @(posedge clk); #1;
    i_new_instance = 1'b0; i_pt_instance = 1'b0;
    early = 0;
    repeat (13) begin @(posedge clk); #1; if (o_tag_ready) early++; end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL abort_early_ready: got %0d cycles high expected 0", early); end
    k = rnd128(); aad = rnd128(); p = rnd128(); iv = rnd128() >> 32;
    gcm_model(k, iv, aad, 64'd40, p, 64'd128, ec, et);
    run_gcm(k, iv, aad, 64'd40, p, 64'd128, 1, lat, r0);
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL abort_latency: got %0d expected 35", lat); end
    checks++;
    if (o_cipher_text !== ec || o_tag !== et) begin
      errors++; $display("FAIL abort_result: got ct=%h tag=%h expected ct=%h tag=%h", o_cipher_text, o_tag, ec, et);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk); #1;
    i_cipher_key = rnd128(); i_new_instance = 1'b1; i_pt_instance = 1'b1;
    i_aad_size = 64'd0; i_plain_text_size = 64'd128;
    @(posedge clk); #1;
    i_new_instance = 1'b0; i_pt_instance = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (o_tag_ready !== 1'b0 || o_cipher_text !== '0 || o_tag !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b ct=%h tag=%h expected all zero", o_tag_ready, o_cipher_text, o_tag);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (o_tag_ready || o_cipher_text !== '0) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midreset_idle: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_partial();
    logic [0:127] ec, et, exp_ct;
    int lat; logic r0;
`ifdef GCM_AES_PARTIAL_BLOCK_EN
    exp_ct = 128'hfc7725319f495c6d0000000000000000;
`else
    exp_ct = 128'hfc7725319f495c6d0cd73d468e4d0187;
`endif
    gcm_model('0, '0, '0, 64'd0, '1, 64'd64, ec, et);
    run_gcm('0, '0, '0, 64'd0, '1, 64'd64, 3, lat, r0);
    checks++;
    if (o_cipher_text !== exp_ct) begin
      errors++; $display("FAIL partial_ct: got %h expected %h", o_cipher_text, exp_ct);
    end
    checks++;
    if (o_tag !== et) begin errors++; $display("FAIL partial_tag: got %h expected %h", o_tag, et); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    test_reset();
    test_known_vectors();
    test_late_pt();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_partial();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
